// File: rtl/iir_dec2_fifo_pkg.sv
// Shared constants for the IIR output path: phase encodings and default sizes.
// Also used by iir_par users, so the values here must stay in step with that block.
package iir_dec2_fifo_pkg;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } phase_t;

    localparam int unsigned W_DEF     = 14;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned AW_DEF    = 2;

endpackage

// File: rtl/dec2_fifo.sv
// Generic circular synchronous FIFO of 2**AW entries, each W+1 bits wide.
// The caller must only push when a slot is free and only pop when count is non-zero.
module dec2_fifo
    import iir_dec2_fifo_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W:0]    din,
    output logic [W:0]    dout,
    output logic [AW:0]   count,
    output logic          full
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    assign dout = mem[rd_ptr];
    assign full = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/iir_dec2_fifo.sv
// Decimate-by-2 averager on the IIR output, buffered into a small FIFO with a
// valid/ready output and a sticky overflow flag.
module iir_dec2_fifo
    import iir_dec2_fifo_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W:0]   y_in,
    input  logic                in_valid,
    output logic signed [W:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [AW:0]         count,
    output logic                overflow
);

    if (DEPTH != (1 << AW)) begin : g_depth_check
        $error("iir_dec2_fifo: DEPTH must equal 2**AW");
    end

    phase_t              phase;
    phase_t              phase_next;
    logic signed [W:0]   hold;
    logic signed [W+1:0] sum;
    logic signed [W:0]   avg;
    logic                push_req;
    logic                push;
    logic                pop;
    logic                full;
    logic [W:0]          fifo_dout;

    // Sign-extend to W+2 bits so the sum never wraps; dropping bit 0 is the
    // arithmetic shift right, and the upper W+1 bits always fit exactly.
    assign sum = $signed({hold[W], hold}) + $signed({y_in[W], y_in});
    assign avg = sum[W+1:1];

    assign push_req = (phase == ODD) && in_valid;
    assign pop      = out_valid && out_ready;
    assign push     = push_req && (!full || pop);

    always_comb begin
        phase_next = phase;
        if (in_valid) begin
            phase_next = (phase == EVEN) ? ODD : EVEN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase    <= EVEN;
            hold     <= '0;
            overflow <= 1'b0;
        end else begin
            phase <= phase_next;
            if (in_valid && phase == EVEN) begin
                hold <= y_in;
            end
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    dec2_fifo #(
        .W  (W),
        .AW (AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (avg),
        .dout  (fifo_dout),
        .count (count),
        .full  (full)
    );

    assign out_data  = $signed(fifo_dout);
    assign out_valid = (count != '0);

endmodule

// File: doc/iir_dec2_fifo.md
# iir_dec2_fifo

Downstream stage for the half-rate parallel IIR filter: it takes the filter's full-rate output samples, decimates by 2 with a two-sample average, and buffers the results in a small FIFO. The buffered stream leaves on a valid/ready handshake. Overflow is reported with a sticky flag. The block sits between the IIR output and the consumer, e.g. a DAC formatter or bus interface, and runs on the same clock as the filter's input side.

## Interface
- W, default 14: sample bit width minus 1, so samples are W+1 bits, signed two's complement.
- DEPTH, default 4: FIFO depth in entries. Must be a power of two, at least 2.
- AW, default 2: FIFO address width; must equal log2(DEPTH).
- clk  input  1  single clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; release is synchronous to clk.
- y_in  input  W+1  signed sample from the IIR output.
- in_valid  input  1  y_in carries a new sample this cycle. Tied high when fed directly by the filter.
- out_data  output  W+1  signed decimated sample at the FIFO head.
- out_valid  output  1  FIFO not empty; out_data is meaningful.
- out_ready  input  1  consumer accepts out_data this cycle when out_valid=1.
- count  output  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky: a decimated sample was dropped because the FIFO was full.

## Operation
- Phase register, states EVEN and ODD, reset to EVEN. Phase toggles only on cycles with in_valid=1.
- EVEN with in_valid: y_in is latched into the hold register; phase becomes ODD.
- ODD with in_valid: avg = (hold + y_in) >>> 1; phase becomes EVEN.
  - The sum is formed at W+2 bits, then arithmetic-shifted, so there is no wrap and rounding is toward negative infinity.
  - The result is truncated back to W+1 bits, which is always exact.
- Push occurs when ODD, in_valid=1 and a slot is free. A slot is free when count<DEPTH, or when count==DEPTH and a pop happens in the same cycle.
- Pop occurs when out_valid=1 and out_ready=1.
- FIFO is circular with wr_ptr/rd_ptr of AW bits; pointers wrap modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Push attempted while full with no pop: the sample is dropped, FIFO contents are unchanged, and overflow is set to 1. overflow stays at 1 until reset.
- Pop while empty is impossible, because out_valid=0.
- out_valid = (count != 0). out_data is mem[rd_ptr]; it is stable while out_valid=1 and out_ready=0.
- in_valid=0 freezes the phase and hold register; FIFO pops still proceed.

## Timing
- Reset values of outputs: out_data=0, out_valid=0, count=0, overflow=0. Reset also sets phase=EVEN, hold=0, wr_ptr=rd_ptr=0, and all memory entries to 0.
- Latency: for an odd sample presented at rising edge n, the average is written at edge n. out_valid is 1 after edge n, so it is visible in cycle n+1 if the FIFO was empty.
- Pop at edge m: the next entry, or out_valid=0, is visible after edge m.
- Throughput: at most one push per 2 valid inputs. A consumer that is always ready never causes overflow.
- Reset asserted mid-operation discards the half-pair in hold and all FIFO contents. The first valid sample after release is treated as EVEN.
- Simultaneous push and pop when count==DEPTH: both occur, count stays DEPTH, overflow is not set.

## Structure
- A shared constants include holds the phase encodings EVEN=1'b0 and ODD=1'b1, and the default W/DEPTH/AW values. These are shared with iir_par users.
- One sub-module: dec2_fifo, a generic synchronous FIFO with parameters W and AW and ports push, pop, din, dout, count and full.
- The top level iir_dec2_fifo holds the phase register, hold register, averager and overflow flag, and instantiates dec2_fifo.

## Test plan
- Reset, then in_valid=1 with y_in = 100, 200, -50, -51; out_ready=1 -> outputs 150, then -51, because (-101)>>>1 = -51. Each output has out_valid high one cycle after its odd sample. overflow=0.
- Extremes at W=14: pair 16383, 16383 -> 16383; pair -16384, -16384 -> -16384. No wrap.
- out_ready=0 with 5 pairs, DEPTH=4 -> count saturates at 4 and overflow=1. Then raise out_ready -> the first 4 averages drain in order, count falls to 0, and overflow stays 1.
- FIFO full, with an odd sample and out_ready=1 in the same cycle -> count stays 4 and the new average is appended. overflow stays 0 if it was previously clear.
- in_valid gaps: samples 10, gap, gap, 30 -> single output 20. Phase is unaffected by the gaps.
- Assert reset between the even and odd sample of a pair, then feed 4, 8 -> single output 6. The stale hold value is not used.
